csr_reg_file: RTL and testbench



---
 rtl/csr_reg_file_pkg.sv | 60 ++++++
 rtl/csr_reg_file_counter64.sv | 32 +++
 rtl/csr_reg_file.sv | 170 +++++++++++++++++
 tb/tb_csr_reg_file.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_reg_file_pkg.sv
// Shared CSR address map, field positions, write masks and the write-request type
// used by the machine-mode / debug CSR file.
package csr_reg_file_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_DCSR      = 12'h7B0;
  localparam logic [11:0] CSR_DPC       = 12'h7B1;
  localparam logic [11:0] CSR_DSCRATCH0 = 12'h7B2;
  localparam logic [11:0] CSR_DSCRATCH1 = 12'h7B3;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIE_MSIE     = 3;
  localparam int MIE_MTIE     = 7;
  localparam int MIE_MEIE     = 11;

  localparam int DCSR_XDEBUGVER_LSB = 28;
  localparam int DCSR_EBREAKM       = 15;
  localparam int DCSR_CAUSE_LSB     = 6;
  localparam int DCSR_STEP          = 2;

  localparam logic [31:0] MSTATUS_RST    = 32'h0000_1800;
  localparam logic [31:0] MSTATUS_WMASK  = 32'h0000_0088;
  localparam logic [31:0] MIE_WMASK      = 32'h0000_0888;
  // The execute stage may only touch ebreakm/step; the controller also owns cause.
  localparam logic [31:0] DCSR_EXU_WMASK = 32'h0000_8004;
  localparam logic [31:0] DCSR_EXC_WMASK = 32'h0000_81C4;
  localparam logic [27:0] DCSR_RST_LOW   = 28'h000_0003;

  typedef enum logic {
    WR_SRC_EXU = 1'b0,
    WR_SRC_EXC = 1'b1
  } wr_src_e;

  typedef struct packed {
    logic        we;
    wr_src_e     src;
    logic [11:0] addr;
    logic [31:0] data;
  } csr_wr_t;

  function automatic logic [31:0] masked_update(input logic [31:0] cur,
                                                input logic [31:0] nxt,
                                                input logic [31:0] mask);
    return (cur & ~mask) | (nxt & mask);
  endfunction

endpackage

// File: rtl/csr_reg_file_counter64.sv
// 64-bit free-running CSR counter with independently writable halves; a write to
// either half replaces it and holds the whole counter for that cycle.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc_i,
  input  logic        we_lo_i,
  input  logic        we_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] q_o
);

  logic [63:0] r_cnt;

  // Counter state: write has priority over increment, carry into hi is the 64-bit add.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 64'h0;
    end else if (we_lo_i) begin
      r_cnt <= {r_cnt[63:32], wdata_i};
    end else if (we_hi_i) begin
      r_cnt <= {wdata_i, r_cnt[31:0]};
    end else if (inc_i) begin
      r_cnt <= r_cnt + 64'd1;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign q_o = r_cnt;

endmodule

// File: rtl/csr_reg_file.sv
// Machine-mode and debug CSR storage: serves execute-stage CSR accesses, accepts
// exception-controller updates (which win on collision) and exports live CSR values.
module csr_reg_file
  import csr_reg_file_pkg::*;
#(
  parameter logic [31:0] HART_ID   = 32'h0000_0000,
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
  parameter logic [31:0] MISA_VAL  = 32'h4000_1100,
  parameter logic [3:0]  XDEBUGVER = 4'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        exu_we_i,
  input  logic [11:0] exu_waddr_i,
  input  logic [31:0] exu_wdata_i,
  input  logic [11:0] exu_raddr_i,
  output logic [31:0] exu_rdata_o,
  output logic        exu_illegal_o,
  input  logic        exc_we_i,
  input  logic [31:0] exc_waddr_i,
  input  logic [31:0] exc_wdata_i,
  input  logic        inst_retire_i,
  input  logic        irq_software_i,
  input  logic        irq_timer_i,
  input  logic        irq_external_i,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o,
  output logic [31:0] mstatus_o,
  output logic [31:0] mie_o,
  output logic [31:0] dpc_o,
  output logic [31:0] dcsr_o
);

  logic [31:0] r_mstatus;
  logic [31:0] r_mie;
  logic [31:0] r_mtvec;
  logic [31:0] r_mscratch;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
  logic [31:0] r_dpc;
  logic [31:0] r_dscratch0;
  logic [31:0] r_dscratch1;
  logic [31:0] r_dcsr;

  csr_wr_t     w_wr;
  logic [31:0] w_mip;
  logic [63:0] w_mcycle;
  logic [63:0] w_minstret;
  logic        w_unused;

  // The controller only writes while the pipeline is stalled, so its write
  // simply replaces any execute-stage write in the same cycle.
  always_comb begin
    w_wr = '0;
    if (exc_we_i) begin
      w_wr.we   = 1'b1;
      w_wr.src  = WR_SRC_EXC;
      w_wr.addr = exc_waddr_i[11:0];
      w_wr.data = exc_wdata_i;
    end else if (exu_we_i) begin
      w_wr.we   = 1'b1;
      w_wr.src  = WR_SRC_EXU;
      w_wr.addr = exu_waddr_i;
      w_wr.data = exu_wdata_i;
    end else begin
      w_wr = '0;
    end
  end

  assign w_unused = ^exc_waddr_i[31:12];

  // CSR storage with per-register write masks; read-only addresses fall to default.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mstatus   <= MSTATUS_RST;
      r_mie       <= 32'h0000_0000;
      r_mtvec     <= MTVEC_RST;
      r_mscratch  <= 32'h0000_0000;
      r_mepc      <= 32'h0000_0000;
      r_mcause    <= 32'h0000_0000;
      r_dpc       <= 32'h0000_0000;
      r_dscratch0 <= 32'h0000_0000;
      r_dscratch1 <= 32'h0000_0000;
      r_dcsr      <= {XDEBUGVER, DCSR_RST_LOW};
    end else if (w_wr.we) begin
      case (w_wr.addr)
        CSR_MSTATUS:   r_mstatus   <= masked_update(r_mstatus, w_wr.data, MSTATUS_WMASK);
        CSR_MIE:       r_mie       <= masked_update(r_mie, w_wr.data, MIE_WMASK);
        CSR_MTVEC:     r_mtvec     <= {w_wr.data[31:2], 2'b00};
        CSR_MSCRATCH:  r_mscratch  <= w_wr.data;
        CSR_MEPC:      r_mepc      <= {w_wr.data[31:1], 1'b0};
        CSR_MCAUSE:    r_mcause    <= w_wr.data;
        CSR_DPC:       r_dpc       <= {w_wr.data[31:1], 1'b0};
        CSR_DSCRATCH0: r_dscratch0 <= w_wr.data;
        CSR_DSCRATCH1: r_dscratch1 <= w_wr.data;
        CSR_DCSR:      r_dcsr      <= masked_update(r_dcsr, w_wr.data,
                                        (w_wr.src == WR_SRC_EXC) ? DCSR_EXC_WMASK
                                                                 : DCSR_EXU_WMASK);
        default:       r_mstatus   <= r_mstatus;
      endcase
    end else begin
      r_mstatus <= r_mstatus;
    end
  end

  csr_counter64 u_mcycle (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (1'b1),
    .we_lo_i (w_wr.we && (w_wr.addr == CSR_MCYCLE)),
    .we_hi_i (w_wr.we && (w_wr.addr == CSR_MCYCLEH)),
    .wdata_i (w_wr.data),
    .q_o     (w_mcycle)
  );

  csr_counter64 u_minstret (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (inst_retire_i),
    .we_lo_i (w_wr.we && (w_wr.addr == CSR_MINSTRET)),
    .we_hi_i (w_wr.we && (w_wr.addr == CSR_MINSTRETH)),
    .wdata_i (w_wr.data),
    .q_o     (w_minstret)
  );

  // Pending-interrupt view is the raw lines, not a stored register.
  always_comb begin
    w_mip           = 32'h0000_0000;
    w_mip[MIE_MSIE] = irq_software_i;
    w_mip[MIE_MTIE] = irq_timer_i;
    w_mip[MIE_MEIE] = irq_external_i;
  end

  // Read mux: no write bypass, so a same-cycle read returns the pre-write value.
  always_comb begin
    exu_rdata_o   = 32'h0000_0000;
    exu_illegal_o = 1'b0;
    case (exu_raddr_i)
      CSR_MSTATUS:   exu_rdata_o = r_mstatus;
      CSR_MISA:      exu_rdata_o = MISA_VAL;
      CSR_MIE:       exu_rdata_o = r_mie;
      CSR_MTVEC:     exu_rdata_o = r_mtvec;
      CSR_MSCRATCH:  exu_rdata_o = r_mscratch;
      CSR_MEPC:      exu_rdata_o = r_mepc;
      CSR_MCAUSE:    exu_rdata_o = r_mcause;
      CSR_MIP:       exu_rdata_o = w_mip;
      CSR_DCSR:      exu_rdata_o = r_dcsr;
      CSR_DPC:       exu_rdata_o = r_dpc;
      CSR_DSCRATCH0: exu_rdata_o = r_dscratch0;
      CSR_DSCRATCH1: exu_rdata_o = r_dscratch1;
      CSR_MCYCLE:    exu_rdata_o = w_mcycle[31:0];
      CSR_MCYCLEH:   exu_rdata_o = w_mcycle[63:32];
      CSR_MINSTRET:  exu_rdata_o = w_minstret[31:0];
      CSR_MINSTRETH: exu_rdata_o = w_minstret[63:32];
      CSR_MHARTID:   exu_rdata_o = HART_ID;
      default: begin
        exu_rdata_o   = 32'h0000_0000;
        exu_illegal_o = 1'b1;
      end
    endcase
  end

  assign mtvec_o   = r_mtvec;
  assign mepc_o    = r_mepc;
  assign mstatus_o = r_mstatus;
  assign mie_o     = r_mie;
  assign dpc_o     = r_dpc;
  assign dcsr_o    = r_dcsr;

endmodule

// File: tb/tb_csr_reg_file.sv
// Directed bench for csr_reg_file: hand-computed expected values for reset state,
// write masks, collisions, debug CSRs, counters, illegal reads and mip mirroring.
module tb_csr_reg_file;

  logic        clk;
  logic        rst_n;
  logic        exu_we_i;
  logic [11:0] exu_waddr_i;
  logic [31:0] exu_wdata_i;
  logic [11:0] exu_raddr_i;
  logic [31:0] exu_rdata_o;
  logic        exu_illegal_o;
  logic        exc_we_i;
  logic [31:0] exc_waddr_i;
  logic [31:0] exc_wdata_i;
  logic        inst_retire_i;
  logic        irq_software_i;
  logic        irq_timer_i;
  logic        irq_external_i;
  logic [31:0] mtvec_o;
  logic [31:0] mepc_o;
  logic [31:0] mstatus_o;
  logic [31:0] mie_o;
  logic [31:0] dpc_o;
  logic [31:0] dcsr_o;

  int n_checks = 0;
  int n_fail   = 0;

  csr_reg_file #(
    .HART_ID   (32'h0000_0005),
    .MTVEC_RST (32'h0000_1000),
    .MISA_VAL  (32'h4000_1100),
    .XDEBUGVER (4'd4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .exu_we_i       (exu_we_i),
    .exu_waddr_i    (exu_waddr_i),
    .exu_wdata_i    (exu_wdata_i),
    .exu_raddr_i    (exu_raddr_i),
    .exu_rdata_o    (exu_rdata_o),
    .exu_illegal_o  (exu_illegal_o),
    .exc_we_i       (exc_we_i),
    .exc_waddr_i    (exc_waddr_i),
    .exc_wdata_i    (exc_wdata_i),
    .inst_retire_i  (inst_retire_i),
    .irq_software_i (irq_software_i),
    .irq_timer_i    (irq_timer_i),
    .irq_external_i (irq_external_i),
    .mtvec_o        (mtvec_o),
    .mepc_o         (mepc_o),
    .mstatus_o      (mstatus_o),
    .mie_o          (mie_o),
    .dpc_o          (dpc_o),
    .dcsr_o         (dcsr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_check(input logic [11:0] addr, input logic [31:0] exp, input string tag);
    exu_raddr_i = addr;
    #1;
    check_eq(tag, exu_rdata_o, exp);
  endtask

  task automatic exu_write(input logic [11:0] addr, input logic [31:0] data);
    exu_we_i    = 1'b1;
    exu_waddr_i = addr;
    exu_wdata_i = data;
    tick();
    exu_we_i    = 1'b0;
  endtask

  task automatic exc_write(input logic [31:0] addr, input logic [31:0] data);
    exc_we_i    = 1'b1;
    exc_waddr_i = addr;
    exc_wdata_i = data;
    tick();
    exc_we_i    = 1'b0;
  endtask

  initial begin
    rst_n          = 1'b0;
    exu_we_i       = 1'b0;
    exu_waddr_i    = 12'h000;
    exu_wdata_i    = 32'h0000_0000;
    exu_raddr_i    = 12'h000;
    exc_we_i       = 1'b0;
    exc_waddr_i    = 32'h0000_0000;
    exc_wdata_i    = 32'h0000_0000;
    inst_retire_i  = 1'b0;
    irq_software_i = 1'b0;
    irq_timer_i    = 1'b0;
    irq_external_i = 1'b0;

    // Reset state
    #12;
    check_eq("rst_mstatus", mstatus_o, 32'h0000_1800);
    check_eq("rst_mtvec",   mtvec_o,   32'h0000_1000);
    check_eq("rst_dcsr",    dcsr_o,    32'h4000_0003);
    check_eq("rst_mie",     mie_o,     32'h0000_0000);
    check_eq("rst_mepc",    mepc_o,    32'h0000_0000);
    check_eq("rst_dpc",     dpc_o,     32'h0000_0000);
    rd_check(12'hF14, 32'h0000_0005, "rd_mhartid");
    rd_check(12'h301, 32'h4000_1100, "rd_misa");
    rd_check(12'hB00, 32'h0000_0000, "rst_mcycle_lo");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Read during write returns the old value, new value one cycle later
    exu_raddr_i = 12'h300;
    exu_we_i    = 1'b1;
    exu_waddr_i = 12'h300;
    exu_wdata_i = 32'hFFFF_FFFF;
    #1;
    check_eq("rdw_old_mstatus", exu_rdata_o, 32'h0000_1800);
    tick();
    exu_we_i = 1'b0;
    check_eq("mstatus_mask", mstatus_o, 32'h0000_1888);
    check_eq("rd_mstatus_new", exu_rdata_o, 32'h0000_1888);

    exu_write(12'h305, 32'h8000_0003);
    check_eq("mtvec_align", mtvec_o, 32'h8000_0000);
    exu_write(12'h304, 32'hFFFF_FFFF);
    check_eq("mie_mask", mie_o, 32'h0000_0888);
    exu_write(12'h7B1, 32'hFFFF_FFFF);
    check_eq("dpc_bit0", dpc_o, 32'hFFFF_FFFE);
    exu_write(12'h7B2, 32'hCAFE_F00D);
    rd_check(12'h7B2, 32'hCAFE_F00D, "rd_dscratch0");
    exu_write(12'h301, 32'h0000_0000);
    rd_check(12'h301, 32'h4000_1100, "misa_ro");

    // Exception-controller sequence; upper address bits are ignored
    exc_write(32'h0000_0342, 32'h8000_000B);
    exc_write(32'hABCD_0300, 32'h0000_0080);
    check_eq("exc_mstatus", mstatus_o, 32'h0000_1880);
    exc_write(32'h0000_0341, 32'h0000_0124);
    check_eq("exc_mepc", mepc_o, 32'h0000_0124);
    rd_check(12'h342, 32'h8000_000B, "rd_mcause");
    rd_check(12'h341, 32'h0000_0124, "rd_mepc");

    // Collisions: exc wins, exu dropped even for a different address
    exc_we_i    = 1'b1;
    exc_waddr_i = 32'h0000_0340;
    exc_wdata_i = 32'hAAAA_5555;
    exu_we_i    = 1'b1;
    exu_waddr_i = 12'h305;
    exu_wdata_i = 32'h0000_0100;
    tick();
    exc_waddr_i = 32'h0000_0340;
    exc_wdata_i = 32'h1111_0000;
    exu_waddr_i = 12'h340;
    exu_wdata_i = 32'h2222_0000;
    check_eq("coll_mtvec_kept", mtvec_o, 32'h8000_0000);
    tick();
    exc_we_i = 1'b0;
    exu_we_i = 1'b0;
    rd_check(12'h340, 32'h1111_0000, "coll_same_addr");

    // dcsr field ownership
    exu_write(12'h7B0, 32'hFFFF_FFFF);
    check_eq("dcsr_exu_mask", dcsr_o, 32'h4000_8007);
    exc_write(32'h0000_07B0, 32'h0000_00C0);
    check_eq("dcsr_exc_cause", {29'd0, dcsr_o[8:6]}, 32'd3);
    exu_write(12'h7B0, 32'h0000_0000);
    check_eq("dcsr_exu_cause_ro", {29'd0, dcsr_o[8:6]}, 32'd3);
    check_eq("dcsr_xdebugver", {28'd0, dcsr_o[31:28]}, 32'd4);

    // mcycle: writes suppress increment, carry into hi on the same edge
    exu_write(12'hB00, 32'hFFFF_FFFE);
    exu_write(12'hB80, 32'h0000_0000);
    rd_check(12'hB00, 32'hFFFF_FFFE, "mcycle_lo_held");
    tick();
    rd_check(12'hB00, 32'hFFFF_FFFF, "mcycle_lo_max");
    tick();
    rd_check(12'hB00, 32'h0000_0000, "mcycle_lo_wrap");
    tick();
    rd_check(12'hB80, 32'h0000_0001, "mcycle_hi_carry");

    // minstret counts retire pulses only
    rd_check(12'hB02, 32'h0000_0000, "minstret_idle");
    for (int i = 0; i < 5; i++) begin
      inst_retire_i = 1'b1;
      tick();
      inst_retire_i = 1'b0;
      tick();
    end
    rd_check(12'hB02, 32'h0000_0005, "minstret_lo");
    rd_check(12'hB82, 32'h0000_0000, "minstret_hi");

    // Unimplemented address and mip mirror
    tick();
    exu_raddr_i = 12'h7C0;
    #1;
    check_eq("illegal_flag", {31'd0, exu_illegal_o}, 32'd1);
    check_eq("illegal_rdata", exu_rdata_o, 32'h0000_0000);
    exu_raddr_i = 12'h300;
    #1;
    check_eq("legal_flag", {31'd0, exu_illegal_o}, 32'd0);
    irq_timer_i = 1'b1;
    rd_check(12'h344, 32'h0000_0080, "mip_timer");
    exu_write(12'h344, 32'hFFFF_FFFF);
    irq_software_i = 1'b1;
    irq_external_i = 1'b1;
    rd_check(12'h344, 32'h0000_0888, "mip_all_ro");

    // Asynchronous reset in mid-operation
    tick();
    rst_n = 1'b0;
    #1;
    check_eq("arst_mstatus", mstatus_o, 32'h0000_1800);
    check_eq("arst_mtvec",   mtvec_o,   32'h0000_1000);
    check_eq("arst_mepc",    mepc_o,    32'h0000_0000);
    check_eq("arst_dcsr",    dcsr_o,    32'h4000_0003);
    rd_check(12'hB02, 32'h0000_0000, "arst_minstret");
    rd_check(12'h340, 32'h0000_0000, "arst_mscratch");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
